note_gate_timer: RTL and testbench

//  Parametrised song-position timer for the note game. Advances noteTime on tick

---
 rtl/note_gate_timer.sv | 172 +++++++++++++++++
 tb/tb_note_gate_timer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_gate_timer.sv
// Song-position timer: advances noteTime on tick and stalls at table checkpoints until the keys in their masks are held.
// Optional feature macro NOTE_TIMEOUT_EN adds a per-checkpoint stall timeout that lands in FAIL.
//
// state  | meaning
// IDLE   | table writable, waiting for start
// RUN    | noteTime advancing, checkpoints resolved one per cycle
// WAIT   | stalled on a checkpoint until its key mask is held
// DONE   | song finished, outputs held, start re-arms
// FAIL   | stall timeout expired (NOTE_TIMEOUT_EN only), start re-arms
module note_gate_timer #(
  parameter int NUM_KEYS = 5,
  parameter int TIME_W   = 21,
  parameter int DEPTH    = 64,
  parameter int IDX_W    = 6,
  parameter int END_TIME = 2600,
  parameter int STALL_W  = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                Noteclk,
  input  logic                reset,
  input  logic                tick,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                start,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_addr,
  input  logic [TIME_W-1:0]   cfg_time,
  input  logic [NUM_KEYS-1:0] cfg_mask,
  input  logic [IDX_W:0]      cfg_count,
  output logic [TIME_W-1:0]   noteTime,
  output logic [IDX_W:0]      cp_idx,
  output logic                stalled,
  output logic [STALL_W-1:0]  stall_ticks,
  output logic                done,
  output logic                fail
);

  localparam logic [TIME_W-1:0] END_T   = TIME_W'(END_TIME);
  localparam logic [IDX_W:0]    DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]    IDX_ONE = (IDX_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DONE
`ifdef NOTE_TIMEOUT_EN
    , S_FAIL
`endif
  } state_t;

  state_t state;

  logic [TIME_W-1:0]   tbl_time [DEPTH];
  logic [NUM_KEYS-1:0] tbl_mask [DEPTH];

  logic [IDX_W:0]      n_cp;
  logic [TIME_W-1:0]   cur_time;
  logic [NUM_KEYS-1:0] cur_mask;
  logic                has_cp;
  logic                hit;
  logic                keys_ok;
  logic                at_end;
  logic [TIME_W-1:0]   time_inc;
  logic [STALL_W-1:0]  stall_inc;
  logic [IDX_W:0]      count_clamped;

`ifdef NOTE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] wait_cnt;
  logic            fail_r;
  assign fail = fail_r;
`else
  assign fail = 1'b0;
`endif

  // Table storage is deliberately not reset; it survives reset and reruns.
  always_ff @(posedge Noteclk) begin
    if (cfg_we && state == S_IDLE) begin
      tbl_time[cfg_addr] <= cfg_time;
      tbl_mask[cfg_addr] <= cfg_mask;
    end
  end

  always_comb begin
    cur_time      = tbl_time[cp_idx[IDX_W-1:0]];
    cur_mask      = tbl_mask[cp_idx[IDX_W-1:0]];
    has_cp        = cp_idx < n_cp;
    hit           = has_cp && (noteTime >= cur_time);
    keys_ok       = (keys & cur_mask) == cur_mask;
    at_end        = (cp_idx == n_cp) && (noteTime >= END_T);
    time_inc      = (noteTime == '1) ? noteTime : noteTime + TIME_W'(1);
    stall_inc     = (stall_ticks == '1) ? stall_ticks : stall_ticks + STALL_W'(1);
    count_clamped = (cfg_count > DEPTH_C) ? DEPTH_C : cfg_count;
  end

  always_ff @(posedge Noteclk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      noteTime    <= '0;
      cp_idx      <= '0;
      n_cp        <= '0;
      stall_ticks <= '0;
      stalled     <= 1'b0;
      done        <= 1'b0;
`ifdef NOTE_TIMEOUT_EN
      wait_cnt    <= '0;
      fail_r      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE
`ifdef NOTE_TIMEOUT_EN
        , S_FAIL
`endif
        : begin
          if (start) begin
            state       <= S_RUN;
            noteTime    <= '0;
            cp_idx      <= '0;
            stall_ticks <= '0;
            n_cp        <= count_clamped;
`ifdef NOTE_TIMEOUT_EN
            fail_r      <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (hit) begin
            if (keys_ok) begin
              cp_idx <= cp_idx + IDX_ONE;
              if (tick) noteTime <= time_inc;
            end else begin
              // Freeze noteTime on the cycle the stall is detected.
              state   <= S_WAIT;
              stalled <= 1'b1;
`ifdef NOTE_TIMEOUT_EN
              wait_cnt <= TO_LOAD;
`endif
            end
          end else if (at_end) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (tick) begin
            noteTime <= time_inc;
          end
        end
        S_WAIT: begin
          if (keys_ok) begin
            cp_idx  <= cp_idx + IDX_ONE;
            state   <= S_RUN;
            stalled <= 1'b0;
          end else if (tick) begin
            stall_ticks <= stall_inc;
`ifdef NOTE_TIMEOUT_EN
            if (wait_cnt == '0) begin
              state   <= S_FAIL;
              fail_r  <= 1'b1;
              stalled <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt - TO_W'(1);
            end
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_gate_timer.sv
// Scoreboard bench for note_gate_timer: stimulus queues expected events, a negedge monitor pops and compares them.
// Build with NOTE_TIMEOUT_EN defined to also exercise the stall timeout path.
module tb_note_gate_timer;

  localparam int NK = 5;
  localparam int TW = 21;
  localparam int IW = 6;
  localparam int SW = 16;

  logic          Noteclk = 1'b0;
  logic          reset;
  logic          tick;
  logic [NK-1:0] keys;
  logic          start;
  logic          cfg_we;
  logic [IW-1:0] cfg_addr;
  logic [TW-1:0] cfg_time;
  logic [NK-1:0] cfg_mask;
  logic [IW:0]   cfg_count;
  logic [TW-1:0] noteTime;
  logic [IW:0]   cp_idx;
  logic          stalled;
  logic [SW-1:0] stall_ticks;
  logic          done;
  logic          fail;

  note_gate_timer #(.TIMEOUT(8)) dut (
    .Noteclk(Noteclk), .reset(reset), .tick(tick), .keys(keys), .start(start),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_time(cfg_time), .cfg_mask(cfg_mask),
    .cfg_count(cfg_count), .noteTime(noteTime), .cp_idx(cp_idx), .stalled(stalled),
    .stall_ticks(stall_ticks), .done(done), .fail(fail)
  );

  always #5 Noteclk = ~Noteclk;

  typedef enum int {EV_CP, EV_STALL, EV_RESUME, EV_DONE, EV_FAIL} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       nt;
    int       cp;
    int       st;   // -1: stall_ticks not compared
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  logic [IW:0] prev_cp      = '0;
  logic        prev_stalled = 1'b0;
  logic        prev_fail    = 1'b0;

`ifdef NOTE_TIMEOUT_EN
  localparam int W4 = 0;
`else
  localparam int W4 = 20;
`endif

  function automatic void expect_ev(ev_kind_t k, int nt, int cp, int st);
    ev_t e;
    e.kind = k; e.nt = nt; e.cp = cp; e.st = st;
    exp_q.push_back(e);
  endfunction

  task automatic observe(ev_kind_t k, int st);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got nt=%0d cp=%0d st=%0d, want no event", k.name(), noteTime, cp_idx, st);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.nt != int'(noteTime) || e.cp != int'(cp_idx) || (e.st >= 0 && e.st != st)) begin
        n_fail++;
        $display("FAIL event_%s: got %s nt=%0d cp=%0d st=%0d, want nt=%0d cp=%0d st=%0d",
                 e.kind.name(), k.name(), noteTime, cp_idx, st, e.nt, e.cp, e.st);
      end
    end
  endtask

  always @(negedge Noteclk) begin
    if (reset) begin
      if (cp_idx == prev_cp + 7'd1)            observe(EV_CP, -1);
      if (stalled && !prev_stalled)            observe(EV_STALL, int'(stall_ticks));
      if (!stalled && prev_stalled && !fail)   observe(EV_RESUME, int'(stall_ticks));
      if (done)                                observe(EV_DONE, -1);
      if (fail && !prev_fail)                  observe(EV_FAIL, int'(stall_ticks));
    end
    prev_cp      <= cp_idx;
    prev_stalled <= stalled;
    prev_fail    <= fail;
  end

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge Noteclk);
    #1;
  endtask

  task automatic write_cp(int addr, int t, logic [NK-1:0] m);
    cfg_addr = IW'(addr);
    cfg_time = TW'(t);
    cfg_mask = m;
    cfg_we   = 1'b1;
    cyc(1);
    cfg_we   = 1'b0;
  endtask

  task automatic do_start(int count);
    cfg_count = (IW+1)'(count);
    start     = 1'b1;
    cyc(1);
    start     = 1'b0;
  endtask

  task automatic rst_pulse();
    cyc(1);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
  endtask

  // which: 0 = done, 1 = stalled, 2 = fail. Returns on a negedge.
  task automatic wait_for(int which, int budget, string name);
    int  k;
    logic s;
    k = 0;
    @(negedge Noteclk);
    s = (which == 0) ? done : (which == 1) ? stalled : fail;
    while (!s && k < budget) begin
      @(negedge Noteclk);
      k++;
      s = (which == 0) ? done : (which == 1) ? stalled : fail;
    end
    n_tests++;
    if (!s) begin
      n_fail++;
      $display("FAIL timeout_%s: got no event in %0d cycles, want event", name, budget);
    end
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; keys = '0; start = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_time = '0; cfg_mask = '0; cfg_count = '0;
    cyc(2);
    chk("rst_noteTime", int'(noteTime), 0);
    chk("rst_cp_idx", int'(cp_idx), 0);
    chk("rst_stalled", int'(stalled), 0);
    chk("rst_stall_ticks", int'(stall_ticks), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fail", int'(fail), 0);
    reset = 1'b1;

    // 1: single C checkpoint at 10, C held; cp resolves at nt 10 and advances to 11 on the same edge.
    write_cp(0, 10, 5'b00001);
    keys = 5'b00001; tick = 1'b1;
    expect_ev(EV_CP, 11, 1, -1);
    expect_ev(EV_DONE, 2600, 1, -1);
    do_start(1);
    wait_for(0, 3000, "t1_done");
    cyc(3);
    chk("t1_done_low", int'(done), 0);
    chk("t1_hold_nt", int'(noteTime), 2600);
    chk("t1_hold_cp", int'(cp_idx), 1);

    // 2: E|G required, only E held -> stall at 10 for 5 ticks, then G added.
    rst_pulse();
    write_cp(0, 10, 5'b10100);
    keys = 5'b00100;
    expect_ev(EV_STALL, 10, 0, 0);
    expect_ev(EV_CP, 10, 1, -1);
    expect_ev(EV_RESUME, 10, 1, 5);
    expect_ev(EV_DONE, 2600, 1, -1);
    do_start(1);
    wait_for(1, 100, "t2_stall");
    repeat (5) @(posedge Noteclk);
    #1;
    chk("t2_frozen_nt", int'(noteTime), 10);
    chk("t2_stall_ticks", int'(stall_ticks), 5);
    keys = 5'b10100;
    wait_for(0, 3000, "t2_done");

    // 3: coincident (20,C),(20,D) then pass-through (25,0); stray start mid-run is ignored.
    rst_pulse();
    write_cp(0, 20, 5'b00001);
    write_cp(1, 20, 5'b00010);
    write_cp(2, 25, 5'b00000);
    keys = 5'b00011;
    expect_ev(EV_CP, 21, 1, -1);
    expect_ev(EV_CP, 22, 2, -1);
    expect_ev(EV_CP, 26, 3, -1);
    expect_ev(EV_DONE, 2600, 3, -1);
    do_start(3);
    cyc(100);
    do_start(1);
    wait_for(0, 3000, "t3_done");

    // 4a: stall on F at 300, then async reset mid-WAIT.
    rst_pulse();
    write_cp(0, 300, 5'b01000);
    keys = 5'b00000;
    expect_ev(EV_STALL, 300, 0, 0);
    do_start(1);
    wait_for(1, 400, "t4_stall");
    cyc(3);
    #2 reset = 1'b0;
    @(negedge Noteclk);
    chk("t4_rst_noteTime", int'(noteTime), 0);
    chk("t4_rst_cp_idx", int'(cp_idx), 0);
    chk("t4_rst_stalled", int'(stalled), 0);
    chk("t4_rst_stall_ticks", int'(stall_ticks), 0);
    chk("t4_rst_done", int'(done), 0);
    chk("t4_rst_fail", int'(fail), 0);
    cyc(1);
    reset = 1'b1;
    cyc(5);
    chk("t4_idle_nt", int'(noteTime), 0);

    // 4b: table survives reset; a write during RUN must not land.
    keys = 5'b00001;
    expect_ev(EV_STALL, 300, 0, 0);
    expect_ev(EV_CP, 300, 1, -1);
    expect_ev(EV_RESUME, 300, 1, W4);
    expect_ev(EV_DONE, 2600, 1, -1);
    do_start(1);
    cyc(2);
    write_cp(0, 5, 5'b00001);
    wait_for(1, 400, "t4b_stall");
    repeat (W4) @(posedge Noteclk);
    #1;
`ifndef NOTE_TIMEOUT_EN
    chk("t4b_no_fail", int'(fail), 0);
    chk("t4b_still_stalled", int'(stalled), 1);
    chk("t4b_frozen_nt", int'(noteTime), 300);
`endif
    keys = 5'b01001;
    wait_for(0, 3000, "t4b_done");

`ifdef NOTE_TIMEOUT_EN
    // 5: mask never met -> FAIL after 8 stall ticks; start clears it.
    rst_pulse();
    write_cp(0, 10, 5'b10000);
    keys = 5'b00000;
    expect_ev(EV_STALL, 10, 0, 0);
    expect_ev(EV_FAIL, 10, 0, 8);
    do_start(1);
    wait_for(2, 100, "t5_fail");
    cyc(3);
    chk("t5_fail_hi", int'(fail), 1);
    chk("t5_stalled_lo", int'(stalled), 0);
    chk("t5_hold_nt", int'(noteTime), 10);
    do_start(0);
    chk("t5_fail_cleared", int'(fail), 0);
    chk("t5_nt_cleared", int'(noteTime), 0);
`endif

    // 6: no checkpoints -> straight to END_TIME; rerun from DONE.
    rst_pulse();
    keys = 5'b00000;
    expect_ev(EV_DONE, 2600, 0, -1);
    do_start(0);
    wait_for(0, 3000, "t6_done");
    cyc(1);
    chk("t6_done_low", int'(done), 0);
    expect_ev(EV_DONE, 2600, 0, -1);
    do_start(0);
    chk("t6_rerun_nt", int'(noteTime), 0);
    wait_for(0, 3000, "t6_done2");

    cyc(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
